inst_fetch_queue: RTL and testbench

Parametrised next-generation fetch unit. Generates fetch PCs with misaligned-start handling, issues block requests to the I-cache over a valid/ready handshake, and keeps up to MAX_OUTSTANDING requests in flight. It tags responses with lane valid masks, truncated at a predicted-taken slot, and buffers them in an OUT_DEPTH-entry queue drained by the instruction buffer with valid/ready. Redirects flush the queue and discard stale in-flight responses.

---
 rtl/inst_fetch_queue_if.sv | 44 ++++
 rtl/inst_fetch_queue.sv | 164 ++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-unit bus: I-cache request/response channel plus the instruction-buffer
// output channel. The fetch unit is the master.
interface inst_fetch_queue_if #(
  parameter int unsigned FETCH_WIDTH = 4
);
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fb_entry_t;

  logic                      core2icache_req_valid;
  logic                      core2icache_req_ready;
  logic [31:0]               core2icache_addr;
  logic [FETCH_WIDTH*32-1:0] icache2core_data;
  logic                      icache2core_data_valid;
  fb_entry_t [FETCH_WIDTH-1:0] insts_out;
  logic [FETCH_WIDTH-1:0]    insts_out_mask;
  logic                      insts_out_valid;
  logic                      insts_out_ready;

  modport master (
    output core2icache_req_valid,
    output core2icache_addr,
    input  core2icache_req_ready,
    input  icache2core_data,
    input  icache2core_data_valid,
    output insts_out,
    output insts_out_mask,
    output insts_out_valid,
    input  insts_out_ready
  );

  modport slave (
    input  core2icache_req_valid,
    input  core2icache_addr,
    output core2icache_req_ready,
    output icache2core_data,
    output icache2core_data_valid,
    input  insts_out,
    input  insts_out_mask,
    input  insts_out_valid,
    output insts_out_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Fetch PC generator with credit-limited I-cache requests, a meta FIFO for
// in-flight blocks and an output queue feeding the instruction buffer.
module inst_fetch_queue #(
  parameter int unsigned FETCH_WIDTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned OUT_DEPTH       = 4,
  parameter logic [31:0] RESET_PC        = 32'h8000_0000
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  input  logic                           pred_taken,
  input  logic [$clog2(FETCH_WIDTH)-1:0] pred_slot,
  input  logic [31:0]                    pred_target,
  inst_fetch_queue_if.master             bus
);
  localparam int unsigned OffW       = $clog2(FETCH_WIDTH);
  localparam int unsigned BlockBytes = FETCH_WIDTH * 4;
  localparam int unsigned DataW      = FETCH_WIDTH * 32;
  localparam int unsigned CntW       = $clog2(OUT_DEPTH + 1);
  localparam int unsigned SumW       = CntW + 1;
  localparam int unsigned QPtrW      = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned MPtrW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]      pc_q, pc_d;
  logic [CntW-1:0]  outstanding_q, outstanding_d;
  logic [CntW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]  q_count_q, q_count_d;
  logic [QPtrW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
  logic [MPtrW-1:0] m_rd_q, m_rd_d, m_wr_q, m_wr_d;

  logic [DataW-1:0]       q_data [OUT_DEPTH];
  logic [31:0]            q_pc   [OUT_DEPTH];
  logic [FETCH_WIDTH-1:0] q_mask [OUT_DEPTH];
  logic [31:0]            m_pc   [MAX_OUTSTANDING];
  logic [FETCH_WIDTH-1:0] m_mask [MAX_OUTSTANDING];

  logic [OffW-1:0]        offset;
  logic [31:0]            block_pc;
  logic [FETCH_WIDTH-1:0] fetch_mask;
  logic                   pred_eff;
  logic                   credit_ok;
  logic                   req_valid;
  logic                   accept;
  logic                   resp;
  logic                   push;
  logic                   pop;

  // Request side: block alignment, lane mask and the credit check.
  always_comb begin
    offset     = pc_q[OffW+1:2];
    block_pc   = pc_q & ~32'(BlockBytes - 1);
    // A taken slot before the start lane is a predictor error; fall through instead.
    pred_eff   = pred_taken && (pred_slot >= offset);
    fetch_mask = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      fetch_mask[i] = (OffW'(i) >= offset) && (!pred_eff || (OffW'(i) <= pred_slot));
    end
    credit_ok = ({1'b0, outstanding_q} + {1'b0, q_count_q}) < SumW'(OUT_DEPTH);
    req_valid = reset_n && !redirect_valid && credit_ok &&
                (outstanding_q < CntW'(MAX_OUTSTANDING));
    accept    = req_valid && bus.core2icache_req_ready;
    resp      = bus.icache2core_data_valid && (outstanding_q != '0);
    push      = resp && (drop_cnt_q == '0) && !redirect_valid;
    pop       = (q_count_q != '0) && bus.insts_out_ready && !redirect_valid;
  end

  // Next-state for PC, counters and pointers.
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CntW'(accept) - CntW'(resp);
    drop_cnt_d    = drop_cnt_q;
    q_count_d     = q_count_q + CntW'(push) - CntW'(pop);
    q_rd_d        = q_rd_q;
    q_wr_d        = q_wr_q;
    m_rd_d        = m_rd_q;
    m_wr_d        = m_wr_q;

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (accept) begin
      pc_d = pred_eff ? pred_target : block_pc + 32'(BlockBytes);
    end

    if (accept) begin
      m_wr_d = (m_wr_q == MPtrW'(MAX_OUTSTANDING - 1)) ? '0 : m_wr_q + MPtrW'(1);
    end
    if (resp) begin
      m_rd_d = (m_rd_q == MPtrW'(MAX_OUTSTANDING - 1)) ? '0 : m_rd_q + MPtrW'(1);
    end

    if (push) begin
      q_wr_d = (q_wr_q == QPtrW'(OUT_DEPTH - 1)) ? '0 : q_wr_q + QPtrW'(1);
    end
    if (pop) begin
      q_rd_d = (q_rd_q == QPtrW'(OUT_DEPTH - 1)) ? '0 : q_rd_q + QPtrW'(1);
    end

    if (redirect_valid) begin
      // Everything still in flight after this cycle's response is stale.
      drop_cnt_d = outstanding_q - CntW'(resp);
      q_count_d  = '0;
      q_rd_d     = '0;
      q_wr_d     = '0;
    end else if (resp && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      q_count_q     <= '0;
      q_rd_q        <= '0;
      q_wr_q        <= '0;
      m_rd_q        <= '0;
      m_wr_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      q_count_q     <= q_count_d;
      q_rd_q        <= q_rd_d;
      q_wr_q        <= q_wr_d;
      m_rd_q        <= m_rd_d;
      m_wr_q        <= m_wr_d;
    end
  end

  // Storage is never read while its occupancy count is zero, so it needs no reset.
  always_ff @(posedge clock) begin
    if (reset_n && accept) begin
      m_pc[m_wr_q]   <= block_pc;
      m_mask[m_wr_q] <= fetch_mask;
    end
    if (reset_n && push) begin
      q_data[q_wr_q] <= bus.icache2core_data;
      q_pc[q_wr_q]   <= m_pc[m_rd_q];
      q_mask[q_wr_q] <= m_mask[m_rd_q];
    end
  end

  always_comb begin
    bus.core2icache_req_valid = req_valid;
    bus.core2icache_addr      = pc_q;
    bus.insts_out_valid       = (q_count_q != '0);
    bus.insts_out_mask        = '0;
    bus.insts_out             = '0;
    if (q_count_q != '0) begin
      bus.insts_out_mask = q_mask[q_rd_q];
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        bus.insts_out[i].inst = q_data[q_rd_q][32*i +: 32];
        bus.insts_out[i].pc   = q_pc[q_rd_q] + 32'(4 * i);
      end
    end
  end

  resp_without_request: assert property (@(posedge clock) disable iff (!reset_n)
    !(bus.icache2core_data_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a small in-order I-cache model.
module tb_inst_fetch_queue;
  localparam int unsigned FW = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        pred_taken;
  logic [1:0]  pred_slot;
  logic [31:0] pred_target;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_acc    = 0;
  logic [31:0] pending[$];
  logic [31:0] seen_pc[$];
  logic [3:0]  seen_mask[$];

  inst_fetch_queue_if #(.FETCH_WIDTH(FW)) bus ();

  inst_fetch_queue #(
    .FETCH_WIDTH(FW),
    .MAX_OUTSTANDING(2),
    .OUT_DEPTH(4),
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .pred_taken(pred_taken),
    .pred_slot(pred_slot),
    .pred_target(pred_target),
    .bus(bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0F0F;
  endfunction

  // One clock: drive the cache response, sample handshakes, step the cache model.
  task automatic cyc(input bit resp_en);
    logic acc, rsp, pp, rst;
    logic [31:0] a;
    if (resp_en && pending.size() > 0) begin
      bus.icache2core_data_valid = 1'b1;
      for (int i = 0; i < FW; i++) bus.icache2core_data[32*i +: 32] = inst_of(pending[0] + 32'(4*i));
    end else begin
      bus.icache2core_data_valid = 1'b0;
      bus.icache2core_data       = '0;
    end
    #1;
    rst = reset_n;
    acc = bus.core2icache_req_valid && bus.core2icache_req_ready;
    rsp = bus.icache2core_data_valid;
    pp  = bus.insts_out_valid && bus.insts_out_ready && !redirect_valid;
    a   = bus.core2icache_addr;
    if (pp) begin
      seen_pc.push_back(bus.insts_out[0].pc);
      seen_mask.push_back(bus.insts_out_mask);
    end
    @(posedge clock);
    @(negedge clock);
    if (!rst) begin
      pending.delete();
    end else begin
      if (rsp) void'(pending.pop_front());
      if (acc) begin
        pending.push_back(a & ~32'hF);
        n_acc++;
      end
    end
    bus.icache2core_data_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    bus.core2icache_req_ready = 1'b0;
    bus.insts_out_ready       = 1'b1;
    while ((pending.size() > 0 || bus.insts_out_valid) && k < 32) begin
      cyc(1);
      k++;
    end
    n_checks++;
    if (pending.size() > 0 || bus.insts_out_valid) begin
      n_fail++;
      $display("FAIL drain_timeout: pending=%0d valid=%b, want 0 and 0", pending.size(),
               bus.insts_out_valid);
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc, input bit resp_en);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cyc(resp_en);
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc(0);
    cyc(0);
    n_checks++;
    if (bus.core2icache_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_req_valid: got %b want 0", bus.core2icache_req_valid);
    end
    n_checks++;
    if (bus.insts_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.insts_out_valid);
    end
    n_checks++;
    if (bus.insts_out_mask !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mask: got %b want 0000", bus.insts_out_mask);
    end
    n_checks++;
    if (bus.insts_out !== '0) begin
      n_fail++; $display("FAIL rst_insts: got %h want 0", bus.insts_out);
    end
    n_checks++;
    if (bus.core2icache_addr !== 32'h8000_0000) begin
      n_fail++; $display("FAIL rst_addr: got %h want 80000000", bus.core2icache_addr);
    end
  endtask

  task automatic test_sequential();
    reset_n                   = 1'b1;
    bus.core2icache_req_ready = 1'b1;
    bus.insts_out_ready       = 1'b1;
    #1;
    n_checks++;
    if (bus.core2icache_req_valid !== 1'b1 || bus.core2icache_addr !== 32'h8000_0000) begin
      n_fail++; $display("FAIL seq_first_req: valid=%b addr=%h want 1/80000000",
                         bus.core2icache_req_valid, bus.core2icache_addr);
    end
    cyc(0);
    n_checks++;
    if (bus.core2icache_addr !== 32'h8000_0010) begin
      n_fail++; $display("FAIL seq_addr1: got %h want 80000010", bus.core2icache_addr);
    end
    cyc(0);
    n_checks++;
    if (bus.core2icache_req_valid !== 1'b0 || bus.core2icache_addr !== 32'h8000_0020) begin
      n_fail++; $display("FAIL seq_max_outstanding: valid=%b addr=%h want 0/80000020",
                         bus.core2icache_req_valid, bus.core2icache_addr);
    end
    cyc(1);
    n_checks++;
    if (bus.insts_out_valid !== 1'b1 || bus.insts_out_mask !== 4'b1111) begin
      n_fail++; $display("FAIL seq_blk0_mask: valid=%b mask=%b want 1/1111",
                         bus.insts_out_valid, bus.insts_out_mask);
    end
    n_checks++;
    if (bus.insts_out[0].pc !== 32'h8000_0000 || bus.insts_out[1].pc !== 32'h8000_0004 ||
        bus.insts_out[2].pc !== 32'h8000_0008 || bus.insts_out[3].pc !== 32'h8000_000C) begin
      n_fail++; $display("FAIL seq_blk0_pcs: got %h %h %h %h want 80000000/4/8/C",
                         bus.insts_out[0].pc, bus.insts_out[1].pc, bus.insts_out[2].pc,
                         bus.insts_out[3].pc);
    end
    n_checks++;
    if (bus.insts_out[2].inst !== 32'hDA5A_0F07) begin
      n_fail++; $display("FAIL seq_blk0_inst2: got %h want da5a0f07", bus.insts_out[2].inst);
    end
    cyc(1);
    n_checks++;
    if (bus.insts_out[0].pc !== 32'h8000_0010 || bus.insts_out[1].pc !== 32'h8000_0014) begin
      n_fail++; $display("FAIL seq_blk1_pcs: got %h %h want 80000010/80000014",
                         bus.insts_out[0].pc, bus.insts_out[1].pc);
    end
    cyc(1);
    n_checks++;
    if (bus.insts_out[0].pc !== 32'h8000_0020 || bus.insts_out_mask !== 4'b1111) begin
      n_fail++; $display("FAIL seq_blk2: pc=%h mask=%b want 80000020/1111",
                         bus.insts_out[0].pc, bus.insts_out_mask);
    end
    drain();
  endtask

  task automatic test_redirect_misaligned();
    redirect_valid            = 1'b1;
    redirect_pc               = 32'h8000_0008;
    bus.core2icache_req_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.core2icache_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_req_valid: got %b want 0", bus.core2icache_req_valid);
    end
    cyc(0);
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.core2icache_addr !== 32'h8000_0008 || bus.core2icache_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL redir_addr: addr=%h valid=%b want 80000008/1",
                         bus.core2icache_addr, bus.core2icache_req_valid);
    end
    cyc(0);
    n_checks++;
    if (bus.core2icache_addr !== 32'h8000_0010) begin
      n_fail++; $display("FAIL redir_next_addr: got %h want 80000010", bus.core2icache_addr);
    end
    bus.core2icache_req_ready = 1'b0;
    cyc(1);
    n_checks++;
    if (bus.insts_out_valid !== 1'b1 || bus.insts_out_mask !== 4'b1100) begin
      n_fail++; $display("FAIL redir_mask: valid=%b mask=%b want 1/1100",
                         bus.insts_out_valid, bus.insts_out_mask);
    end
    n_checks++;
    if (bus.insts_out[2].pc !== 32'h8000_0008 || bus.insts_out[3].pc !== 32'h8000_000C) begin
      n_fail++; $display("FAIL redir_lane_pcs: got %h %h want 80000008/8000000c",
                         bus.insts_out[2].pc, bus.insts_out[3].pc);
    end
    drain();
  endtask

  task automatic test_predict();
    redirect_to(32'h8000_0000, 0);
    bus.core2icache_req_ready = 1'b1;
    pred_taken  = 1'b1;
    pred_slot   = 2'd1;
    pred_target = 32'h8000_0104;
    cyc(0);
    pred_taken = 1'b0;
    #1;
    n_checks++;
    if (bus.core2icache_addr !== 32'h8000_0104) begin
      n_fail++; $display("FAIL pred_target_addr: got %h want 80000104", bus.core2icache_addr);
    end
    cyc(0);
    bus.core2icache_req_ready = 1'b0;
    n_checks++;
    if (bus.core2icache_addr !== 32'h8000_0110) begin
      n_fail++; $display("FAIL pred_after_target: got %h want 80000110", bus.core2icache_addr);
    end
    cyc(1);
    n_checks++;
    if (bus.insts_out_mask !== 4'b0011 || bus.insts_out[1].pc !== 32'h8000_0004) begin
      n_fail++; $display("FAIL pred_taken_mask: mask=%b pc1=%h want 0011/80000004",
                         bus.insts_out_mask, bus.insts_out[1].pc);
    end
    cyc(1);
    n_checks++;
    if (bus.insts_out_mask !== 4'b1110 || bus.insts_out[1].pc !== 32'h8000_0104) begin
      n_fail++; $display("FAIL pred_target_mask: mask=%b pc1=%h want 1110/80000104",
                         bus.insts_out_mask, bus.insts_out[1].pc);
    end
    drain();
    // Taken slot before the start lane must be ignored.
    redirect_to(32'h8000_0208, 0);
    bus.core2icache_req_ready = 1'b1;
    pred_taken  = 1'b1;
    pred_slot   = 2'd1;
    pred_target = 32'h8000_0400;
    cyc(0);
    pred_taken = 1'b0;
    bus.core2icache_req_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.core2icache_addr !== 32'h8000_0210) begin
      n_fail++; $display("FAIL pred_error_addr: got %h want 80000210", bus.core2icache_addr);
    end
    cyc(1);
    n_checks++;
    if (bus.insts_out_mask !== 4'b1100) begin
      n_fail++; $display("FAIL pred_error_mask: got %b want 1100", bus.insts_out_mask);
    end
    drain();
  endtask

  task automatic test_backpressure();
    redirect_to(32'h8000_2000, 0);
    bus.insts_out_ready       = 1'b0;
    bus.core2icache_req_ready = 1'b1;
    n_acc = 0;
    repeat (10) cyc(1);
    n_checks++;
    if (n_acc != 4) begin
      n_fail++; $display("FAIL bp_accepts: got %0d want 4", n_acc);
    end
    n_checks++;
    if (bus.core2icache_req_valid !== 1'b0 || bus.insts_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_full: req_valid=%b out_valid=%b want 0/1",
                         bus.core2icache_req_valid, bus.insts_out_valid);
    end
    n_checks++;
    if (bus.insts_out[0].pc !== 32'h8000_2000) begin
      n_fail++; $display("FAIL bp_head: got %h want 80002000", bus.insts_out[0].pc);
    end
    seen_pc.delete();
    seen_mask.delete();
    drain();
    n_checks++;
    if (seen_pc.size() != 4) begin
      n_fail++; $display("FAIL bp_drain_count: got %0d want 4", seen_pc.size());
    end
    for (int i = 0; i < 4 && i < seen_pc.size(); i++) begin
      n_checks++;
      if (seen_pc[i] !== 32'h8000_2000 + 32'(16*i) || seen_mask[i] !== 4'b1111) begin
        n_fail++; $display("FAIL bp_drain_%0d: pc=%h mask=%b want %h/1111", i, seen_pc[i],
                           seen_mask[i], 32'h8000_2000 + 32'(16*i));
      end
    end
  endtask

  task automatic test_redirect_drop();
    int k = 0;
    redirect_to(32'h8000_3000, 0);
    bus.core2icache_req_ready = 1'b1;
    bus.insts_out_ready       = 1'b0;
    cyc(0);
    cyc(0);
    n_checks++;
    if (bus.core2icache_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_two_outstanding: req_valid=%b want 0",
                         bus.core2icache_req_valid);
    end
    // Back-to-back redirects, the first one coinciding with a stale response.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_5000;
    cyc(1);
    redirect_pc    = 32'h8000_1000;
    cyc(0);
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.insts_out_valid !== 1'b0 || bus.core2icache_addr !== 32'h8000_1000) begin
      n_fail++; $display("FAIL drop_after_redirect: valid=%b addr=%h want 0/80001000",
                         bus.insts_out_valid, bus.core2icache_addr);
    end
    while (!bus.insts_out_valid && k < 12) begin
      cyc(1);
      k++;
    end
    n_checks++;
    if (bus.insts_out_valid !== 1'b1 || bus.insts_out[0].pc !== 32'h8000_1000) begin
      n_fail++; $display("FAIL drop_first_visible: valid=%b pc=%h want 1/80001000",
                         bus.insts_out_valid, bus.insts_out[0].pc);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    redirect_to(32'h8000_6000, 0);
    bus.insts_out_ready       = 1'b0;
    bus.core2icache_req_ready = 1'b1;
    repeat (10) cyc(1);
    n_checks++;
    if (bus.insts_out_valid !== 1'b1 || bus.core2icache_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_full: out_valid=%b req_valid=%b want 1/0",
                         bus.insts_out_valid, bus.core2icache_req_valid);
    end
    reset_n = 1'b0;
    cyc(0);
    n_checks++;
    if (bus.insts_out_valid !== 1'b0 || bus.insts_out_mask !== 4'b0000 ||
        bus.insts_out !== '0 || bus.core2icache_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: valid=%b mask=%b insts=%h req=%b want zeros",
                         bus.insts_out_valid, bus.insts_out_mask, bus.insts_out,
                         bus.core2icache_req_valid);
    end
    n_checks++;
    if (bus.core2icache_addr !== 32'h8000_0000) begin
      n_fail++; $display("FAIL mid_reset_addr: got %h want 80000000", bus.core2icache_addr);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (bus.core2icache_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_release_req: got %b want 1", bus.core2icache_req_valid);
    end
  endtask

  initial begin
    reset_n                    = 1'b0;
    redirect_valid             = 1'b0;
    redirect_pc                = '0;
    pred_taken                 = 1'b0;
    pred_slot                  = '0;
    pred_target                = '0;
    bus.core2icache_req_ready  = 1'b0;
    bus.icache2core_data       = '0;
    bus.icache2core_data_valid = 1'b0;
    bus.insts_out_ready        = 1'b0;
    @(negedge clock);
    test_reset();
    test_sequential();
    test_redirect_misaligned();
    test_predict();
    test_backpressure();
    test_redirect_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
